spart_bus_ctrl: RTL

- Sole master of the SPART processor-side bus (iocs, iorw, ioaddr, databus).
- Programs the baud divisor after reset and whenever br_cfg changes.
- Shares the bus between a TX client (byte stream in) and an RX client (byte stream out) under fixed priority.
- Replaces ad-hoc bus sequencing in the top level. The board-side driver logic connects to the client handshakes only.

---
 rtl/spart_pkg.sv | 23 ++
 rtl/sync2.sv | 24 ++
 rtl/spart_bus_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared constants and state encoding for the SPART bus controller.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF = 2'b00;
    localparam logic [1:0] ADDR_DBL = 2'b10;
    localparam logic [1:0] ADDR_DBH = 2'b11;

    // Baud divisors for 100 MHz with 16x oversampling, indexed by br_cfg.
    localparam logic [15:0] DIV_4800_DEF  = 16'd1301;
    localparam logic [15:0] DIV_9600_DEF  = 16'd650;
    localparam logic [15:0] DIV_19200_DEF = 16'd324;
    localparam logic [15:0] DIV_38400_DEF = 16'd161;

    typedef enum logic [2:0] {
        ST_CFG_LO,
        ST_CFG_HI,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_GAP
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous inputs such as switches.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta and q sample together, giving two real stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Sole master of the SPART processor bus: programs the baud divisor and
// arbitrates RX reads ahead of TX writes, with one dead cycle after each access.
import spart_pkg::*;

module spart_bus_ctrl #(
    parameter logic [15:0] DIV_4800  = DIV_4800_DEF,
    parameter logic [15:0] DIV_9600  = DIV_9600_DEF,
    parameter logic [15:0] DIV_19200 = DIV_19200_DEF,
    parameter logic [15:0] DIV_38400 = DIV_38400_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       cfg_busy
);

    state_t      state;
    logic [1:0]  br_sync;
    logic [1:0]  cur_cfg;
    logic [1:0]  cfg_sel;
    logic [1:0]  warm;
    logic [15:0] div;
    logic [7:0]  wr_q;
    logic        cfg_req;
    logic        rd_req;

    sync2 #(.WIDTH(2)) u_br_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (br_cfg),
        .q     (br_sync)
    );

    // The high byte must come from the value latched for the low byte.
    // NOTE: div gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cfg_sel = (state == ST_CFG_LO && iocs) ? cur_cfg : br_sync;
        div     = DIV_4800;
        case (cfg_sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
    end

    assign cfg_req  = (br_sync != cur_cfg);
    assign rd_req   = rda && !rx_valid;
    assign tx_ready = (state == ST_IDLE) && !cfg_busy && !cfg_req && !rd_req
                      && tx_valid && tbr;
    assign databus  = (iocs && !iorw) ? wr_q : 8'bz;

    // Bus outputs are registered for the state being entered; the default is a released bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CFG_LO;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_BUF;
            wr_q     <= '0;
            cur_cfg  <= '0;
            warm     <= '0;
            cfg_busy <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            iocs   <= 1'b0;
            iorw   <= 1'b1;
            ioaddr <= ADDR_BUF;

            case (state)
                ST_CFG_LO: begin
                    // After reset, wait for the synchroniser to fill before latching br_sync.
                    if (!iocs) begin
                        if (warm == 2'd2) begin
                            cur_cfg <= br_sync;
                            iocs    <= 1'b1;
                            iorw    <= 1'b0;
                            ioaddr  <= ADDR_DBL;
                            wr_q    <= div[7:0];
                        end else begin
                            warm <= warm + 2'd1;
                        end
                    end else begin
                        state  <= ST_CFG_HI;
                        iocs   <= 1'b1;
                        iorw   <= 1'b0;
                        ioaddr <= ADDR_DBH;
                        wr_q   <= div[15:8];
                    end
                end
                ST_CFG_HI: state <= ST_GAP;
                ST_IDLE: begin
                    if (cfg_req) begin
                        state    <= ST_CFG_LO;
                        cur_cfg  <= br_sync;
                        cfg_busy <= 1'b1;
                        iocs     <= 1'b1;
                        iorw     <= 1'b0;
                        ioaddr   <= ADDR_DBL;
                        wr_q     <= div[7:0];
                    end else if (rd_req) begin
                        state <= ST_RD;
                        iocs  <= 1'b1;
                    end else if (tx_ready) begin
                        state <= ST_WR;
                        iocs  <= 1'b1;
                        iorw  <= 1'b0;
                        wr_q  <= tx_data;
                    end
                end
                ST_RD: begin
                    rx_data  <= databus;
                    rx_valid <= 1'b1;
                    state    <= ST_GAP;
                end
                ST_WR: state <= ST_GAP;
                ST_GAP: begin
                    state    <= ST_IDLE;
                    cfg_busy <= 1'b0;
                end
                default: begin
                    state    <= ST_CFG_LO;
                    cfg_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule
